// File: rtl/exp2_pkg.sv
// Shared definitions for the sequential base-2 antilog unit: default field
// widths, FSM state encoding and the fractional-power constant generator.
package exp2_pkg;

  localparam int DEF_FRAC_W = 16;
  localparam int DEF_INT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Floor square root of a 128-bit integer (restoring, two bits per step).
  function automatic logic [127:0] isqrt128(input logic [127:0] n);
    logic [127:0] rem;
    logic [127:0] res;
    logic [127:0] b;
    rem = n;
    res = '0;
    for (int i = 63; i >= 0; i--) begin
      b = 128'(1) << (2 * i);
      if (rem >= res + b) begin
        rem = rem - (res + b);
        res = (res >> 1) + b;
      end else begin
        res = res >> 1;
      end
    end
    return res;
  endfunction

  // C[k] = round(2^(2^-(k+1)) * 2^31). Built by repeated square roots of 2.0
  // carried in Q2.62 so the final rounding to Q1.31 is unaffected by the
  // truncation of the intermediate roots.
  function automatic logic [31:0] exp2_const(input int k);
    logic [127:0] v;
    v = 128'(1) << 63;
    for (int j = 0; j <= k; j++) begin
      v = isqrt128(v << 62);
    end
    return 32'((v + (128'(1) << 30)) >> 31);
  endfunction

endpackage

// File: rtl/exp2_const_rom.sv
// Combinational lookup of the fractional-power multiplier C[k].
module exp2_const_rom
  import exp2_pkg::*;
#(
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int K_W    = $clog2(FRAC_W)
) (
  input  logic [K_W-1:0] i_k,
  output logic [31:0]    o_c
);

  logic [31:0] w_tab [FRAC_W];

  for (genvar g = 0; g < FRAC_W; g++) begin : g_tab
    assign w_tab[g] = exp2_const(g);
  end

  assign o_c = w_tab[i_k];

endmodule

// File: rtl/exp2_seq.sv
// Sequential base-2 antilog: result = floor(2^a) for an unsigned fixed-point
// exponent a. The fraction is resolved MSB-first, one bit per cycle, by
// multiplying a Q1.31 mantissa with C[k] for every set bit; the integer part
// of the exponent is then applied as a single right shift.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for an operand; latch e, f, ovf and start m at 1.0
// ST_ITER  | one fraction bit per cycle, k = 0..FRAC_W-1
// ST_SHIFT | scale mantissa by 2^e (or saturate), load the result
// ST_DONE  | result valid and frozen until the consumer accepts it
module exp2_seq
  import exp2_pkg::*;
#(
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int INT_W  = DEF_INT_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_a,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_result,
  output logic        o_ovf
);

  localparam int K_W = $clog2(FRAC_W);

  state_t             r_state;
  state_t             w_next;
  logic [INT_W-1:0]   r_e;
  logic [FRAC_W-1:0]  r_f;
  logic               r_ovf;
  logic [31:0]        r_m;
  logic [K_W-1:0]     r_k;
  logic [31:0]        r_result;
  logic               r_ovf_out;

  logic [31:0]        w_c;
  logic [63:0]        w_prod;
  logic [31:0]        w_m_mul;
  logic [4:0]         w_shamt;
  logic               w_last;
  logic               w_unused_prod;

  exp2_const_rom #(
    .FRAC_W (FRAC_W),
    .K_W    (K_W)
  ) u_rom (
    .i_k (r_k),
    .o_c (w_c)
  );

  // The mantissa stays in [1.0, 2.0), so product bit 63 is always clear and
  // bits [62:31] are the renormalised Q1.31 value.
  assign w_prod        = 64'(r_m) * 64'(w_c);
  assign w_m_mul       = w_prod[62:31];
  assign w_unused_prod = ^{w_prod[63], w_prod[30:0]};
  assign w_shamt       = 5'(32'd31 - 32'(r_e));
  assign w_last        = (r_k == K_W'(FRAC_W - 1));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = i_rst_n;
        if (i_in_valid) w_next = ST_ITER;
      end
      ST_ITER: begin
        if (w_last) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture, fraction iteration and final scaling.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_e       <= '0;
      r_f       <= '0;
      r_ovf     <= 1'b0;
      r_m       <= '0;
      r_k       <= '0;
      r_result  <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_e   <= i_a[FRAC_W+INT_W-1:FRAC_W];
            r_f   <= i_a[FRAC_W-1:0];
            r_ovf <= |i_a[31:FRAC_W+INT_W];
            r_m   <= 32'h8000_0000;
            r_k   <= '0;
          end
        end
        ST_ITER: begin
          if (r_f[FRAC_W-1]) r_m <= w_m_mul;
          r_f <= r_f << 1;
          r_k <= r_k + 1'b1;
        end
        ST_SHIFT: begin
          r_result  <= r_ovf ? 32'hFFFF_FFFF : (r_m >> w_shamt);
          r_ovf_out <= r_ovf;
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_ovf    = r_ovf_out;

endmodule
